memory_interface: RTL
=====================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter ADDR_BITS, default 9, SHALL set the RAM word-address width (512 words).
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15, SHALL set the extra RAM read-latency cycles.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-005 clr  input  1  SHALL be the asynchronous active-low reset.
REQ-006 rd_req  input  1  SHALL request a read at mar_in.
REQ-007 wr_req  input  1  SHALL request a write of mdr_in at mar_in.
REQ-008 mar_in  input  32  SHALL carry the word address from the datapath MAR.
REQ-009 mdr_in  input  32  SHALL carry the write data from the datapath MDR.
REQ-010 mdatain  output  32  SHALL carry read data to the datapath MDMux Mdatain input.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 err  output  1  SHALL be a one-cycle rejected-request pulse.
REQ-014 ram_en, ram_we  output  1 each  SHALL be the RAM enable and write strobe.
REQ-015 ram_addr  output  ADDR_BITS  SHALL be the RAM address; ram_wdata  output  32  SHALL be the RAM write data.
REQ-016 ram_rdata  input  32  SHALL be the synchronous RAM read data, valid at least one cycle after ram_en.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE.
REQ-018 IDLE: a valid request sampled on edge 0 SHALL latch the address low bits, mdr_in and the operation, then go to ACCESS.
REQ-019 A request SHALL be valid when exactly one of rd_req/wr_req is high and mar_in[31:ADDR_BITS] is zero.
REQ-020 When both rd_req and wr_req are high, or the address is out of range, the block SHALL pulse err for cycle 1, stay in IDLE, and leave ram_en, ram_we and done low.
REQ-021 ACCESS (cycle 1): ram_en=1, ram_we=1 only for a write, and ram_addr/ram_wdata driven from the latches; the next state SHALL be WAIT.
REQ-022 WAIT SHALL last WAIT_CYCLES+1 cycles, counted by a down-counter loaded on entry, with ram_en=0 and ram_we=0.
REQ-023 For a read, ram_rdata SHALL be captured into mdatain on the final WAIT edge; a write SHALL leave mdatain unchanged.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE, giving done in cycle WAIT_CYCLES+3 after the sampling edge.
REQ-025 mdatain SHALL hold its value until the next read capture.
REQ-026 Requests while busy=1 SHALL be ignored and not queued.
REQ-027 A request held high through DONE SHALL be re-sampled in IDLE as a new request.
REQ-028 ram_we SHALL be high for exactly one cycle per accepted write; ram_addr and ram_wdata SHALL hold the latched values between accesses.

Reset
REQ-029 While clr=0, the state SHALL be IDLE and mdatain, done, busy, err, ram_en, ram_we, ram_addr, ram_wdata and the wait counter SHALL all be 0, asynchronously.
REQ-030 Reset mid-operation SHALL abort the access with no done pulse, and any partial read SHALL be discarded.

Structure
REQ-031 State encodings and the default ADDR_BITS/WAIT_CYCLES values SHALL live in the shared cpu_defs.vh include.
REQ-032 The wait counter SHALL be the single sub-module, wait_counter (load, decrement, zero flag).
REQ-033 The RAM SHALL be external to this block.

Verification
REQ-034 Read: RAM[0x005]=0x1234ABCD, WAIT_CYCLES=1, rd_req at edge 0 -> ram_en in cycle 1, done in cycle 4, mdatain=0x1234ABCD.
REQ-035 Write: mar_in=0x1FF, mdr_in=0xDEADBEEF -> ram_we=1 only in cycle 1 with ram_addr=0x1FF and ram_wdata=0xDEADBEEF; done in cycle 4; mdatain unchanged.
REQ-036 rd_req=wr_req=1, or mar_in=0x200 -> err=1 in cycle 1; no ram_en, no done; busy stays 0.
REQ-037 rd_req pulsed in cycles 2 and 3 of an active write -> ignored: exactly one ram_en and one done.
REQ-038 clr=0 during WAIT of a read -> outputs 0 immediately, no done; a fresh read after release completes normally.
REQ-039 WAIT_CYCLES=0 read -> done in cycle 3 with correct data; WAIT_CYCLES=15 -> done in cycle 18.

Source files
------------

// File: rtl/memory_interface_pkg.sv
// memory_interface_pkg: FSM state encoding and default geometry shared by the memory interface.
package memory_interface_pkg;
  localparam int DEF_ADDR_BITS   = 9;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int CNT_W           = 4;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/memory_interface_wait_counter.sv
// wait_counter: loadable down-counter with a zero flag that times the RAM read latency.
module wait_counter
  import memory_interface_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = load_i ? value_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge clr)
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/memory_interface.sv
// memory_interface: single-access FSM (IDLE/ACCESS/WAIT/DONE) between the datapath MAR/MDR and an external synchronous RAM.
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [31:0]          mar_in,
  input  logic [31:0]          mdr_in,
  output logic [31:0]          mdatain,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
);
  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic                 wr_q, wr_d, err_q, err_d;
  logic                 req_valid, load, dec, zero;
  assign req_valid = (rd_req ^ wr_req) && (mar_in >> ADDR_BITS) == 32'd0;
  wait_counter u_wait (
    .clk    (clk),
    .clr    (clr),
    .load_i (load),
    .dec_i  (dec),
    .value_i(CNT_W'(WAIT_CYCLES)),
    .zero_o (zero)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = (rd_req | wr_req) && !req_valid;
        if (req_valid) begin
          state_d = S_ACCESS;
          addr_d  = mar_in[ADDR_BITS-1:0];
          wdata_d = mdr_in;
          wr_d    = wr_req;
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        load    = 1'b1;
      end
      S_WAIT: begin
        dec     = !zero;
        state_d = zero ? S_DONE : S_WAIT;
        rdata_d = (zero && !wr_q) ? ram_rdata : rdata_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  assign mdatain   = rdata_q;
  assign done      = state_q == S_DONE;
  assign busy      = state_q != S_IDLE;
  assign err       = err_q;
  assign ram_en    = state_q == S_ACCESS;
  assign ram_we    = ram_en && wr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
endmodule
